// File: rtl/wb_stage.sv
// Writeback stage: selects ALU / load / PC+4 result, formats load data, drives the RF write port.
// Latency: 1 cycle accept->write for non-loads; loads stall in WAIT until dmem_rvalid_i. in_ready_o low only in WAIT.
module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_i,
    input  logic                  rd_we_i,
    input  logic [1:0]            wb_sel_i,
    input  logic [DATA_WIDTH-1:0] alu_res_i,
    input  logic [DATA_WIDTH-1:0] pc_plus4_i,
    input  logic [2:0]            ld_funct3_i,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_rw_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    output logic                  ld_pending_o,
    output logic [ADDR_WIDTH-1:0] ld_pending_rd_o,
    output logic                  misalign_o,
    output logic [31:0]           retire_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  mis_q;
    logic [ADDR_WIDTH-1:0] rw_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [31:0]           retire_q;

    logic                  accept;
    logic                  is_load;
    logic                  mis_acc;
    logic                  acc_writes;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;

    assign in_ready_o = (state_q != WAIT);
    assign accept     = in_valid_i && in_ready_o;
    assign is_load    = (wb_sel_i == 2'b01);
    assign mis_acc    = is_load &&
                        (((ld_funct3_i[1:0] == 2'b01) && alu_res_i[0]) ||
                         ((ld_funct3_i == 3'b010) && (alu_res_i[1:0] != 2'b00)));
    assign acc_writes = rd_we_i && (rd_i != '0) && !mis_acc;
    assign sel_data   = (wb_sel_i == 2'b10) ? pc_plus4_i : alu_res_i;

    assign ld_byte = dmem_rdata_i[{off_q, 3'b000} +: 8];
    assign ld_half = off_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

    always_comb begin
        ld_data = dmem_rdata_i;
        case (f3_q)
            3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WRITE: begin
                if (accept) state_d = (is_load && !mis_acc) ? WAIT : WRITE;
                else        state_d = IDLE;
            end
            WAIT:    if (dmem_rvalid_i) state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // rw_q/wdata_q only move when a real write is about to issue, so the port holds its last write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q     <= '0;
            we_q     <= 1'b0;
            f3_q     <= '0;
            off_q    <= '0;
            mis_q    <= 1'b0;
            rw_q     <= '0;
            wdata_q  <= '0;
            retire_q <= '0;
        end else begin
            if (accept) begin
                rd_q  <= rd_i;
                we_q  <= rd_we_i && !mis_acc;
                f3_q  <= ld_funct3_i;
                off_q <= alu_res_i[1:0];
                mis_q <= mis_acc;
                if (acc_writes && !is_load) begin
                    rw_q    <= rd_i;
                    wdata_q <= sel_data;
                end
            end
            if ((state_q == WAIT) && dmem_rvalid_i && we_q && (rd_q != '0)) begin
                rw_q    <= rd_q;
                wdata_q <= ld_data;
            end
            if (state_q == WRITE) retire_q <= retire_q + 32'd1;
        end
    end

    assign rf_we_o         = (state_q == WRITE) && we_q && (rd_q != '0);
    assign rf_rw_o         = rw_q;
    assign rf_wdata_o      = wdata_q;
    assign ld_pending_o    = (state_q == WAIT);
    assign ld_pending_rd_o = (state_q == WAIT) ? rd_q : '0;
    assign misalign_o      = (state_q == WRITE) && mis_q;
    assign retire_cnt_o    = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed vector table, reset-during-load sequence, randomized run vs. reference model.
module tb_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [4:0]  rd_i = '0;
    logic        rd_we_i = 1'b0;
    logic [1:0]  wb_sel_i = '0;
    logic [31:0] alu_res_i = '0;
    logic [31:0] pc_plus4_i = '0;
    logic [2:0]  ld_funct3_i = '0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i = '0;
    logic        rf_we_o;
    logic [4:0]  rf_rw_o;
    logic [31:0] rf_wdata_o;
    logic        ld_pending_o;
    logic [4:0]  ld_pending_rd_o;
    logic        misalign_o;
    logic [31:0] retire_cnt_o;

    wb_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .rd_i(rd_i), .rd_we_i(rd_we_i), .wb_sel_i(wb_sel_i),
        .alu_res_i(alu_res_i), .pc_plus4_i(pc_plus4_i), .ld_funct3_i(ld_funct3_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .rf_we_o(rf_we_o), .rf_rw_o(rf_rw_o), .rf_wdata_o(rf_wdata_o),
        .ld_pending_o(ld_pending_o), .ld_pending_rd_o(ld_pending_rd_o),
        .misalign_o(misalign_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_retire = 0;
    logic [4:0]  last_rw = '0;
    logic [31:0] last_wd = '0;

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          dly;
        logic        exp_we;
        logic [31:0] exp_data;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: straight from the load-format and alignment rules.
    function automatic logic model_mis(input logic [2:0] f3, input logic [1:0] off);
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
        if (f3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd5:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic issue(input vec_t v, input string tag);
        int guard = 0;
        in_valid_i   = 1'b1;
        wb_sel_i     = v.sel;
        rd_i         = v.rd;
        rd_we_i      = v.we;
        alu_res_i    = v.alu;
        pc_plus4_i   = v.pc4;
        ld_funct3_i  = v.f3;
        dmem_rdata_i = v.rdata;
        while (!in_ready_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 20) chk({tag, "_ready_timeout"}, 32'(in_ready_o), 32'd1);
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        if (v.sel == 2'b01 && !v.exp_mis) begin
            for (int i = 0; i < v.dly; i++) begin
                @(negedge clk_i);
                chk({tag, "_pending"}, 32'(ld_pending_o), 32'd1);
                chk({tag, "_pending_rd"}, 32'(ld_pending_rd_o), 32'(v.rd));
                chk({tag, "_wait_ready"}, 32'(in_ready_o), 32'd0);
                if (i == v.dly - 1) dmem_rvalid_i = 1'b1;
            end
            @(posedge clk_i);
            #1 dmem_rvalid_i = 1'b0;
        end
        @(negedge clk_i);
        if (v.exp_we) begin
            last_rw = v.rd;
            last_wd = v.exp_data;
        end
        chk({tag, "_we"}, 32'(rf_we_o), 32'(v.exp_we));
        chk({tag, "_rw"}, 32'(rf_rw_o), 32'(last_rw));
        chk({tag, "_wdata"}, rf_wdata_o, last_wd);
        chk({tag, "_misalign"}, 32'(misalign_o), 32'(v.exp_mis));
        chk({tag, "_nopend"}, 32'(ld_pending_o), 32'd0);
        chk({tag, "_ready"}, 32'(in_ready_o), 32'd1);
        chk({tag, "_retire"}, retire_cnt_o, exp_retire);
        exp_retire++;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        logic is_ld;
        //           sel    rd   we  alu            pc4        f3    rdata          dly exp_we exp_data       exp_mis
        vecs[0]  = '{2'b00, 5,  1, 32'h1234,      32'h0,     3'd0, 32'h0,          0, 1, 32'h0000_1234, 0};
        vecs[1]  = '{2'b00, 1,  1, 32'h11,        32'h0,     3'd0, 32'h0,          0, 1, 32'h0000_0011, 0};
        vecs[2]  = '{2'b00, 2,  1, 32'h22,        32'h0,     3'd0, 32'h0,          0, 1, 32'h0000_0022, 0};
        vecs[3]  = '{2'b00, 3,  1, 32'h33,        32'h0,     3'd0, 32'h0,          0, 1, 32'h0000_0033, 0};
        vecs[4]  = '{2'b01, 7,  1, 32'h1003,      32'h0,     3'd0, 32'h80FF_0000,  4, 1, 32'hFFFF_FF80, 0};
        vecs[5]  = '{2'b01, 8,  1, 32'h1003,      32'h0,     3'd4, 32'h80FF_0000,  4, 1, 32'h0000_0080, 0};
        vecs[6]  = '{2'b01, 9,  1, 32'h1001,      32'h0,     3'd1, 32'h0,          1, 0, 32'h0,         1};
        vecs[7]  = '{2'b10, 0,  1, 32'h0,         32'h104,   3'd0, 32'h0,          0, 0, 32'h0,         0};
        vecs[8]  = '{2'b01, 10, 1, 32'h2002,      32'h0,     3'd5, 32'h89AB_CDEF,  1, 1, 32'h0000_89AB, 0};
        vecs[9]  = '{2'b01, 11, 1, 32'h2000,      32'h0,     3'd1, 32'h1234_8001,  2, 1, 32'hFFFF_8001, 0};
        vecs[10] = '{2'b01, 12, 1, 32'h3000,      32'h0,     3'd2, 32'hDEAD_BEEF,  3, 1, 32'hDEAD_BEEF, 0};
        vecs[11] = '{2'b01, 13, 1, 32'h3002,      32'h0,     3'd2, 32'h0,          1, 0, 32'h0,         1};
        vecs[12] = '{2'b11, 14, 1, 32'hCAFE,      32'h0,     3'd0, 32'h0,          0, 1, 32'h0000_CAFE, 0};
        vecs[13] = '{2'b00, 15, 0, 32'h5555,      32'h0,     3'd0, 32'h0,          0, 0, 32'h0,         0};
        vecs[14] = '{2'b01, 16, 1, 32'h0001,      32'h0,     3'd0, 32'h0000_7F00,  2, 1, 32'h0000_007F, 0};

        #3;
        chk("rst_ready", 32'(in_ready_o), 32'd1);
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_rw", 32'(rf_rw_o), 32'd0);
        chk("rst_wdata", rf_wdata_o, 32'd0);
        chk("rst_pending", 32'(ld_pending_o), 32'd0);
        chk("rst_pending_rd", 32'(ld_pending_rd_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        chk("rst_retire", retire_cnt_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        for (int i = 0; i < 15; i++) issue(vecs[i], $sformatf("vec%0d", i));
        @(negedge clk_i);
        chk("vec_retire_total", retire_cnt_o, exp_retire);

        // Reset while a load is outstanding: nothing may be written afterwards.
        in_valid_i = 1'b1; wb_sel_i = 2'b01; rd_i = 5'd20; rd_we_i = 1'b1;
        ld_funct3_i = 3'd2; alu_res_i = 32'h100; dmem_rdata_i = 32'h5555_5555;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rstwait_pending_before", 32'(ld_pending_o), 32'd1);
        rst_i = 1'b1;
        #1;
        chk("rstwait_pending", 32'(ld_pending_o), 32'd0);
        chk("rstwait_ready", 32'(in_ready_o), 32'd1);
        chk("rstwait_retire", retire_cnt_o, 32'd0);
        chk("rstwait_wdata", rf_wdata_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_retire = 0; last_rw = '0; last_wd = '0;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b1;
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("rstwait_no_write", 32'(rf_we_o), 32'd0);
            chk("rstwait_no_retire", retire_cnt_o, 32'd0);
        end

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid_i    = 1'b0;
                dmem_rvalid_i = 1'($urandom_range(0, 1));
                @(negedge clk_i);
                dmem_rvalid_i = 1'b0;
                chk("rand_idle_we", 32'(rf_we_o), 32'd0);
            end
            case ($urandom_range(0, 4))
                0:       r.sel = 2'b00;
                1, 2:    r.sel = 2'b01;
                3:       r.sel = 2'b10;
                default: r.sel = 2'b11;
            endcase
            r.rd    = 5'($urandom_range(0, 31));
            r.we    = ($urandom_range(0, 7) != 0);
            r.alu   = $urandom;
            r.pc4   = $urandom;
            case ($urandom_range(0, 5))
                0:       r.f3 = 3'd0;
                1:       r.f3 = 3'd1;
                2:       r.f3 = 3'd2;
                3:       r.f3 = 3'd4;
                4:       r.f3 = 3'd5;
                default: r.f3 = 3'd3;
            endcase
            r.rdata = $urandom;
            r.dly   = $urandom_range(1, 4);
            is_ld   = (r.sel == 2'b01);
            r.exp_mis  = is_ld && model_mis(r.f3, r.alu[1:0]);
            r.exp_we   = r.we && (r.rd != 0) && !r.exp_mis;
            r.exp_data = is_ld ? model_load(r.f3, r.alu[1:0], r.rdata)
                               : ((r.sel == 2'b10) ? r.pc4 : r.alu);
            issue(r, "rand");
        end
        @(negedge clk_i);
        chk("rand_retire_total", retire_cnt_o, exp_retire);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the 5-stage RV32I core.
- Sits between the MEM/WB boundary and the register file write port.
- Selects the result source (ALU, load data, PC+4), and aligns and extends load data.
- Waits on the data-memory response for loads; drives the register-file write port, forwarding/hazard info and a retire counter.

Parameters:
- DATA_WIDTH, 32, datapath width; only 32 supported.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  MEM stage presents an instruction
- in_ready_o  out  1  stage can accept this cycle
- rd_i  in  ADDR_WIDTH  destination register
- rd_we_i  in  1  instruction writes rd
- wb_sel_i  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 reserved (treated as ALU)
- alu_res_i  in  DATA_WIDTH  ALU result (for loads, the effective address)
- pc_plus4_i  in  DATA_WIDTH  link value
- ld_funct3_i  in  3  load type
- dmem_rvalid_i  in  1  load data valid
- dmem_rdata_i  in  DATA_WIDTH  raw aligned memory word
- rf_we_o  out  1  register-file write enable
- rf_rw_o  out  ADDR_WIDTH  register-file write index
- rf_wdata_o  out  DATA_WIDTH  register-file write data
- ld_pending_o  out  1  load outstanding
- ld_pending_rd_o  out  ADDR_WIDTH  rd of outstanding load
- misalign_o  out  1  one-cycle pulse on misaligned load
- retire_cnt_o  out  32  retired-instruction count

Behaviour:
- Reset: state IDLE; all outputs 0 except in_ready_o=1; retire_cnt_o=0. Reset asserted mid-load drops the load and any pending write; no write is issued after reset release.
- States:
  - IDLE: in_ready_o=1; rf_we_o=0.
  - WAIT: in_ready_o=0; ld_pending_o=1; ld_pending_rd_o=latched rd.
  - WRITE: in_ready_o=1; rf_* outputs valid for exactly one cycle.
- Accept = in_valid_i && in_ready_o, legal in IDLE or WRITE.
  - Non-load accept: latch rd, we and the selected data; next state WRITE. Latency is 1 cycle from accept to rf_we_o. Back-to-back non-loads retire 1 per cycle.
  - Load accept: latch rd, we, funct3 and alu_res_i[1:0]; next state WAIT.
- WAIT:
  - Hold until dmem_rvalid_i=1, then format data, latch it, and go to WRITE.
  - A response in the same cycle as entry is impossible: entry is registered.
  - dmem_rvalid_i is ignored outside WAIT.
- Load formatting uses byte offset o = addr[1:0]:
  - LB (000): sign-extend byte o.
  - LBU (100): zero-extend byte o.
  - LH (001): sign-extend half addr[1].
  - LHU (101): zero-extend half addr[1].
  - LW (010) and other codes: full word.
- Misaligned load: LH/LHU with o[0]=1, or LW with o!=0, is detected at accept.
  - Do not enter WAIT; go to WRITE with the write suppressed.
  - Pulse misalign_o in that WRITE cycle.
  - The instruction still retires.
- rf_we_o = WRITE && latched we && latched rd != 0. Never write x0.
- rf_rw_o and rf_wdata_o hold their last values when rf_we_o=0.
- retire_cnt_o increments by 1 in every WRITE cycle and wraps at 2^32-1 → 0.
- in_valid_i while in WAIT: not accepted; the upstream stage must hold its inputs.

Test Plan:
- ADD result: accept rd=5, sel=ALU, alu=0x1234 → next cycle rf_we_o=1, rw=5, wdata=0x00001234; retire_cnt=1.
- Three back-to-back ALU ops (rd 1, 2, 3) → three consecutive rf_we_o pulses; in_ready_o stays 1; retire_cnt=3.
- LB, addr_lo=3, rdata=0x80FF_0000, rvalid 4 cycles later → ld_pending_o=1 and in_ready_o=0 for 4 cycles, then wdata=0xFFFFFF80. Repeat as LBU → 0x00000080.
- LH with addr_lo=1 → misalign_o pulses, rf_we_o=0, no WAIT entered, retire_cnt increments.
- JAL link with rd=0, pc_plus4=0x104 → WRITE cycle occurs with rf_we_o=0; retire_cnt increments.
- Assert rst_i during WAIT, then deassert and later pulse dmem_rvalid_i → immediately state IDLE, ld_pending_o=0, retire_cnt=0; no write is produced.
